// File: rtl/brc_arb_pkg.sv
// Shared types and funct3 decode helpers for the branch-comparator share arbiter.
package brc_arb_pkg;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_BLT  = 3'b100,
        OP_BGE  = 3'b101,
        OP_BLTU = 3'b110,
        OP_BGEU = 3'b111
    } cmp_op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic result;
        logic err;
    } cmp_res_t;

    // Map comparator flags to the 1-bit outcome; 010/011 are illegal.
    function automatic cmp_res_t cmp_resolve(input logic [2:0] op,
                                             input logic       less,
                                             input logic       equal);
        cmp_res_t r;
        r.result = 1'b0;
        r.err    = 1'b0;
        case (op)
            OP_BEQ:  r.result = equal;
            OP_BNE:  r.result = !equal;
            OP_BLT:  r.result = less;
            OP_BGE:  r.result = !less;
            OP_BLTU: r.result = less;
            OP_BGEU: r.result = !less;
            default: r.err    = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_BLT) || (op == OP_BGE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first asserted request at or after the pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    localparam int unsigned IDXW = $clog2(NUM_REQ);

    int unsigned w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_j = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDXW'(w_j);
            end
        end
    end

endmodule

// File: rtl/brc_share_arbiter.sv
// Shares one branch comparator among NUM_REQ requesters with a registered response slot.
// Optional counters are compiled in with BRC_ARB_STATS_EN.
module brc_share_arbiter
    import brc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*XLEN-1:0]    i_req_rs1,
    input  logic [NUM_REQ*XLEN-1:0]    i_req_rs2,
    input  logic [NUM_REQ*3-1:0]       i_req_op,
    output logic [XLEN-1:0]            o_brc_rs1,
    output logic [XLEN-1:0]            o_brc_rs2,
    output logic                       o_brc_un,
    input  logic                       i_brc_less,
    input  logic                       i_brc_equal,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic                       o_rsp_result,
    output logic                       o_rsp_err
`ifdef BRC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]      o_grant_cnt,
    output logic [31:0]                o_stall_cnt
`endif
);
    localparam int unsigned IDXW = $clog2(NUM_REQ);
    localparam int unsigned CNTW = 32;

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IDXW-1:0]     r_ptr;
    logic [IDXW-1:0]     r_rsp_id;
    logic                r_rsp_result;
    logic                r_rsp_err;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IDXW-1:0]     w_gidx;
    logic [IDXW-1:0]     w_sel;
    logic                w_any;
    logic                w_can_accept;
    logic                w_hs;
    logic [2:0]          w_op;
    cmp_res_t            w_res;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs)                                    w_state_nxt = S_FULL;
        else if ((r_state == S_FULL) && i_rsp_ready) w_state_nxt = S_EMPTY;
    end

    // Grant, operand steering and decode; idle cycles show the pointer's requester.
    always_comb begin
        w_can_accept = (r_state == S_EMPTY) || i_rsp_ready;
        w_hs         = i_rst_n && w_can_accept && w_any;
        o_req_ready  = w_hs ? w_grant : '0;
        w_sel        = w_hs ? w_gidx : r_ptr;
        o_brc_rs1    = '0;
        o_brc_rs2    = '0;
        w_op         = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            if (IDXW'(n) == w_sel) begin
                o_brc_rs1 = i_req_rs1[n*XLEN +: XLEN];
                o_brc_rs2 = i_req_rs2[n*XLEN +: XLEN];
                w_op      = i_req_op[n*3 +: 3];
            end
        end
        o_brc_un    = w_hs && op_is_signed(w_op);
        w_res       = cmp_resolve(w_op, i_brc_less, i_brc_equal);
        o_rsp_valid = (r_state == S_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr        <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (w_hs) begin
            r_rsp_id     <= w_gidx;
            r_rsp_result <= w_res.result;
            r_rsp_err    <= w_res.err;
            r_ptr        <= (32'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
        end
    end

    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_err    = r_rsp_err;

`ifdef BRC_ARB_STATS_EN
    logic [NUM_REQ*CNTW-1:0] r_grant_cnt;
    logic [CNTW-1:0]         r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned n = 0; n < NUM_REQ; n++) begin
                if (w_hs && w_grant[n])
                    r_grant_cnt[n*CNTW +: CNTW] <= r_grant_cnt[n*CNTW +: CNTW] + 1'b1;
            end
            if ((r_state == S_FULL) && !i_rsp_ready && (|i_req_valid))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_grant_cnt = r_grant_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_brc_share_arbiter.sv
// Directed plus randomized bench for brc_share_arbiter against a cycle-level reference model.
module tb_brc_share_arbiter;
    localparam int N = 2;
    localparam int X = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*X-1:0] req_rs1;
    logic [N*X-1:0] req_rs2;
    logic [N*3-1:0] req_op;
    logic [X-1:0]   brc_rs1;
    logic [X-1:0]   brc_rs2;
    logic           brc_un;
    logic           brc_less;
    logic           brc_equal;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [0:0]     rsp_id;
    logic           rsp_result;
    logic           rsp_err;
`ifdef BRC_ARB_STATS_EN
    logic [N*32-1:0] grant_cnt;
    logic [31:0]     stall_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    bit m_full;
    int m_ptr;
    int m_id;
    bit m_res;
    bit m_err;
    int m_g;

    always #5 clk = ~clk;

    // comparator attached to the shared port
    always_comb begin
        brc_equal = (brc_rs1 == brc_rs2);
        brc_less  = brc_un ? ($signed(brc_rs1) < $signed(brc_rs2)) : (brc_rs1 < brc_rs2);
    end

    brc_share_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_rs1    (req_rs1),
        .i_req_rs2    (req_rs2),
        .i_req_op     (req_op),
        .o_brc_rs1    (brc_rs1),
        .o_brc_rs2    (brc_rs2),
        .o_brc_un     (brc_un),
        .i_brc_less   (brc_less),
        .i_brc_equal  (brc_equal),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_err    (rsp_err)
`ifdef BRC_ARB_STATS_EN
        ,
        .o_grant_cnt  (grant_cnt),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output bit res, output bit err);
        err = 1'b0;
        res = 1'b0;
        case (op)
            3'd0: res = (a == b);
            3'd1: res = (a != b);
            3'd4: res = ($signed(a) < $signed(b));
            3'd5: res = !($signed(a) < $signed(b));
            3'd6: res = (a < b);
            3'd7: res = (a >= b);
            default: err = 1'b1;
        endcase
    endfunction

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic step();
        int           g;
        int           sel;
        logic [N-1:0] exp_rdy;
        logic [2:0]   gop;
        @(negedge clk);
        g = -1;
        if (rst_n && (!m_full || rsp_ready))
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        sel = (g >= 0) ? g : m_ptr;
        gop = req_op[sel*3 +: 3];
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full) begin
            check("rsp_id",     64'(rsp_id),     64'(m_id));
            check("rsp_result", 64'(rsp_result), 64'(m_res));
            check("rsp_err",    64'(rsp_err),    64'(m_err));
        end
        check("brc_rs1", 64'(brc_rs1), 64'(req_rs1[sel*X +: X]));
        check("brc_rs2", 64'(brc_rs2), 64'(req_rs2[sel*X +: X]));
        check("brc_un",  64'(brc_un),  64'(g >= 0 && (gop == 3'd4 || gop == 3'd5)));
        @(posedge clk);
        if (!rst_n) begin
            m_full = 1'b0; m_ptr = 0; m_id = 0; m_res = 1'b0; m_err = 1'b0;
        end else if (g >= 0) begin
            m_full = 1'b1;
            m_id   = g;
            ref_decode(gop, req_rs1[g*X +: X], req_rs2[g*X +: X], m_res, m_err);
            m_ptr  = (g + 1) % N;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        m_g = rst_n ? g : -1;
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        req_valid[n]       = v;
        req_rs1[n*X +: X]  = a;
        req_rs2[n*X +: X]  = b;
        req_op[n*3 +: 3]   = op;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        m_full = 1'b0; m_ptr = 0; m_id = 0; m_res = 1'b0; m_err = 1'b0; m_g = -1;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'd3, 32'd3, 3'b000);
        set_req(1, 1'b1, 32'd4, 32'd9, 3'b100);
        #1;

        // reset held with all requesters valid
        repeat (3) step();
        check("rst_rsp_id",     64'(rsp_id),     64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_err",    64'(rsp_err),    64'd0);

        // single signed then unsigned less-than on requester 0
        rst_n = 1'b1;
        req_valid = '0;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100);
        step();
        req_valid[0] = 1'b0;
        step();
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b110);
        step();
        req_valid[0] = 1'b0;
        step();

        // both requesters streaming with the consumer always ready
        set_req(0, 1'b1, 32'd5, 32'd5, 3'b000);
        set_req(1, 1'b1, 32'd5, 32'd5, 3'b001);
        repeat (4) step();

        // back-pressure with the slot full, then release
        rsp_ready = 1'b0;
        repeat (4) step();
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (2) step();

        // illegal funct3 on requester 1, then confirm the pointer moved on
        set_req(1, 1'b1, 32'd7, 32'd3, 3'b010);
        step();
        req_valid[1] = 1'b0;
        step();
        set_req(0, 1'b1, 32'd1, 32'd2, 3'b101);
        set_req(1, 1'b1, 32'd2, 32'd1, 3'b111);
        step();
        req_valid = '0;
        step();

        // reset while holding an unconsumed response
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'd8, 32'd9, 3'b110);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 32'd9, 32'd8, 3'b110);
        step();
        rst_n = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
`ifdef BRC_ARB_STATS_EN
        check("grant_cnt_rst", 64'(grant_cnt), 64'd0);
        check("stall_cnt_rst", 64'(stall_cnt), 64'd0);
`endif
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'd2, 32'd2, 3'b000);
        set_req(1, 1'b1, 32'd2, 32'd3, 3'b000);
        step();
        req_valid = '0;
        step();

        // randomized traffic honouring hold-until-handshake
        repeat (400) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < N; n++) begin
                if (!req_valid[n] || m_g == n) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(n, 1'b1, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
                    else
                        req_valid[n] = 1'b0;
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
